// File: rtl/evo_scheduler_pkg.sv
// ============================================================================
//  Module      : evo_scheduler_pkg
//  Description : Shared command bit indices, FSM state codes and LFSR helper
//                for the LifeGame cell-map scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package evo_scheduler_pkg;

    // Command bit positions within envo_ctrl_cmd
    localparam int C_CMD_CLR      = 0;
    localparam int C_CMD_INC_V    = 1;
    localparam int C_CMD_DEC_V    = 2;
    localparam int C_CMD_USR_DATA = 3;
    localparam int C_CMD_USR_SET  = 4;
    localparam int C_CMD_RANDOM   = 5;
    localparam int C_CMD_PAUSE    = 6;
    localparam int C_CMD_STEP     = 7;

    // Scheduler state codes; the encoding is visible on the debug display
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RANDOM = 3'd2,
        ST_USET   = 3'd3,
        ST_EVOLVE = 3'd4
    } state_e;

    localparam logic [15:0] C_LFSR_SEED = 16'hACE1;

    // Fibonacci LFSR step, taps 16,14,13,11 (bits 15,13,12,10), shifting left
    function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/evo_scheduler_lfsr16.sv
// ============================================================================
//  Module      : lfsr16
//  Description : Free-running 16-bit Fibonacci LFSR used as the random-fill
//                bit source. Advances every clock regardless of activity.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr16
    import evo_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] out
);

    logic [15:0] r_lfsr_q;
    logic [15:0] w_lfsr_d;

    // Next LFSR value
    always_comb begin
        w_lfsr_d = lfsr16_next(r_lfsr_q);
    end

    // LFSR register, reseeded by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr_q <= C_LFSR_SEED;
        end else begin
            r_lfsr_q <= w_lfsr_d;
        end
    end

    assign out = r_lfsr_q;

endmodule

`default_nettype wire

// File: rtl/evo_scheduler.sv
// ============================================================================
//  Module      : evo_scheduler
//  Description : Sequencer/arbiter for the LifeGame cell map. Owns the shared
//                cell memory and grants it to clear sweep, random fill, user
//                cell write or an evolution step; paces evolution from a
//                programmable speed with pause and single-step.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module evo_scheduler
    import evo_scheduler_pkg::*;
#(
    parameter  int MAP_WIDTH  = 16,
    parameter  int MAP_HEIGHT = 16,
    parameter  int DIV_BASE   = 1_000_000,
    parameter  int SPEED_MAX  = 7,
    localparam int AW         = $clog2(MAP_WIDTH * MAP_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    envo_ctrl_cmd,
    input  logic [6:0]    cursor_x,
    input  logic [6:0]    cursor_y,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wdata,
    output logic          mem_we,
    output logic          gen_start,
    input  logic          gen_done,
    output logic [2:0]    speed,
    output logic          paused,
    output logic          busy,
    output logic [15:0]   gen_count,
    output logic [2:0]    state
);

    localparam int          C_CELLS     = MAP_WIDTH * MAP_HEIGHT;
    localparam logic [AW-1:0] C_LAST    = AW'(C_CELLS - 1);
    localparam logic [2:0]  C_SPEED_MAX = 3'(SPEED_MAX);
    localparam logic [2:0]  C_SPEED_RST = 3'd3;

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    state_e        r_state_q,     w_state_d;
    logic          r_p_clr_q,     w_p_clr_d;
    logic          r_p_rnd_q,     w_p_rnd_d;
    logic          r_p_set_q,     w_p_set_d;
    logic          r_p_step_q,    w_p_step_d;
    logic          r_p_tick_q,    w_p_tick_d;
    logic          r_set_val_q,   w_set_val_d;
    logic [2:0]    r_speed_q,     w_speed_d;
    logic          r_paused_q,    w_paused_d;
    logic [31:0]   r_pace_q,      w_pace_d;
    logic [AW-1:0] r_addr_q,      w_addr_d;
    logic          r_wdata_q,     w_wdata_d;
    logic          r_we_q,        w_we_d;
    logic          r_gen_start_q, w_gen_start_d;
    logic          r_busy_q,      w_busy_d;
    logic [15:0]   r_gen_count_q, w_gen_count_d;

    // Flag consumption strobes raised when the FSM leaves IDLE
    logic          w_take_clr;
    logic          w_take_rnd;
    logic          w_take_set;
    logic          w_take_step;
    logic          w_take_tick;

    logic [15:0]   w_lfsr;
    logic [31:0]   w_period;
    logic          w_pace_tc;
    logic          w_cur_ok;
    logic [AW-1:0] w_cur_addr;

    lfsr16 u_lfsr16 (
        .clk (clk),
        .rst (rst),
        .out (w_lfsr)
    );

    // Cursor address and range check; out-of-map cursors never write
    always_comb begin
        w_cur_ok   = (int'(cursor_x) < MAP_WIDTH) && (int'(cursor_y) < MAP_HEIGHT);
        w_cur_addr = AW'(int'(cursor_y) * MAP_WIDTH + int'(cursor_x));
    end

    // Speed, pause and pace divider; INC/DEC/PAUSE act in every state
    always_comb begin
        w_speed_d = r_speed_q;
        if (envo_ctrl_cmd[C_CMD_INC_V] && !envo_ctrl_cmd[C_CMD_DEC_V] &&
            (r_speed_q != C_SPEED_MAX)) begin
            w_speed_d = r_speed_q + 3'd1;
        end else if (envo_ctrl_cmd[C_CMD_DEC_V] && !envo_ctrl_cmd[C_CMD_INC_V] &&
                     (r_speed_q != 3'd0)) begin
            w_speed_d = r_speed_q - 3'd1;
        end

        w_paused_d = r_paused_q ^ envo_ctrl_cmd[C_CMD_PAUSE];

        // Each step down in speed doubles the tick period
        w_period  = 32'(DIV_BASE) << (C_SPEED_MAX - r_speed_q);
        w_pace_tc = !r_paused_q && (r_pace_q == (w_period - 32'd1));

        w_pace_d = r_pace_q;
        if (w_speed_d != r_speed_q) begin
            w_pace_d = 32'd0;
        end else if (!r_paused_q) begin
            w_pace_d = w_pace_tc ? 32'd0 : (r_pace_q + 32'd1);
        end
    end

    // Scheduler FSM: next state plus the registered memory/control outputs
    always_comb begin
        w_state_d     = r_state_q;
        w_addr_d      = '0;
        w_we_d        = 1'b0;
        w_wdata_d     = 1'b0;
        w_gen_start_d = 1'b0;
        w_gen_count_d = r_gen_count_q;
        w_take_clr    = 1'b0;
        w_take_rnd    = 1'b0;
        w_take_set    = 1'b0;
        w_take_step   = 1'b0;
        w_take_tick   = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (r_p_clr_q) begin
                    w_take_clr    = 1'b1;
                    w_state_d     = ST_CLEAR;
                    w_we_d        = 1'b1;
                    w_gen_count_d = 16'd0;
                end else if (r_p_rnd_q) begin
                    w_take_rnd = 1'b1;
                    w_state_d  = ST_RANDOM;
                    w_we_d     = 1'b1;
                    w_wdata_d  = w_lfsr[0];
                end else if (r_p_set_q) begin
                    w_take_set = 1'b1;
                    w_state_d  = ST_USET;
                    w_we_d     = w_cur_ok;
                    w_addr_d   = w_cur_ok ? w_cur_addr : '0;
                    w_wdata_d  = w_cur_ok ? r_set_val_q : 1'b0;
                end else if (r_p_step_q || r_p_tick_q) begin
                    // A step request is consumed first; a held tick then
                    // produces its own generation afterwards
                    w_take_step   = r_p_step_q;
                    w_take_tick   = !r_p_step_q;
                    w_state_d     = ST_EVOLVE;
                    w_gen_start_d = 1'b1;
                end
            end

            ST_CLEAR, ST_RANDOM: begin
                if (r_addr_q == C_LAST) begin
                    w_state_d = ST_IDLE;
                end else begin
                    w_addr_d  = r_addr_q + AW'(1);
                    w_we_d    = 1'b1;
                    w_wdata_d = (r_state_q == ST_RANDOM) ? w_lfsr[0] : 1'b0;
                end
            end

            ST_USET: begin
                w_state_d = ST_IDLE;
            end

            ST_EVOLVE: begin
                // Memory outputs stay inactive while the engine owns the map
                if (gen_done) begin
                    w_gen_count_d = r_gen_count_q + 16'd1;
                    w_state_d     = ST_IDLE;
                end
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        w_busy_d = (w_state_d != ST_IDLE);
    end

    // Sticky pending flags; a pulse on an already-pending flag is absorbed
    always_comb begin
        w_p_clr_d   = (r_p_clr_q  | envo_ctrl_cmd[C_CMD_CLR])     & ~w_take_clr;
        w_p_rnd_d   = (r_p_rnd_q  | envo_ctrl_cmd[C_CMD_RANDOM])  & ~w_take_rnd;
        w_p_set_d   = (r_p_set_q  | envo_ctrl_cmd[C_CMD_USR_SET]) & ~w_take_set;
        w_p_step_d  = (r_p_step_q | envo_ctrl_cmd[C_CMD_STEP])    & ~w_take_step;
        // A tick landing on the consumption cycle must not be lost
        w_p_tick_d  = (r_p_tick_q & ~w_take_tick) | w_pace_tc;
        w_set_val_d = envo_ctrl_cmd[C_CMD_USR_SET] ? envo_ctrl_cmd[C_CMD_USR_DATA]
                                                   : r_set_val_q;
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_p_clr_q     <= 1'b0;
            r_p_rnd_q     <= 1'b0;
            r_p_set_q     <= 1'b0;
            r_p_step_q    <= 1'b0;
            r_p_tick_q    <= 1'b0;
            r_set_val_q   <= 1'b0;
            r_speed_q     <= C_SPEED_RST;
            r_paused_q    <= 1'b0;
            r_pace_q      <= 32'd0;
            r_addr_q      <= '0;
            r_wdata_q     <= 1'b0;
            r_we_q        <= 1'b0;
            r_gen_start_q <= 1'b0;
            r_busy_q      <= 1'b0;
            r_gen_count_q <= 16'd0;
        end else begin
            r_state_q     <= w_state_d;
            r_p_clr_q     <= w_p_clr_d;
            r_p_rnd_q     <= w_p_rnd_d;
            r_p_set_q     <= w_p_set_d;
            r_p_step_q    <= w_p_step_d;
            r_p_tick_q    <= w_p_tick_d;
            r_set_val_q   <= w_set_val_d;
            r_speed_q     <= w_speed_d;
            r_paused_q    <= w_paused_d;
            r_pace_q      <= w_pace_d;
            r_addr_q      <= w_addr_d;
            r_wdata_q     <= w_wdata_d;
            r_we_q        <= w_we_d;
            r_gen_start_q <= w_gen_start_d;
            r_busy_q      <= w_busy_d;
            r_gen_count_q <= w_gen_count_d;
        end
    end

    assign mem_addr  = r_addr_q;
    assign mem_wdata = r_wdata_q;
    assign mem_we    = r_we_q;
    assign gen_start = r_gen_start_q;
    assign speed     = r_speed_q;
    assign paused    = r_paused_q;
    assign busy      = r_busy_q;
    assign gen_count = r_gen_count_q;
    assign state     = r_state_q;

endmodule

`default_nettype wire

// File: doc/evo_scheduler.md
# evo_scheduler

Sequencer and arbiter for the LifeGame cell map. It sits between the keyboard command decoder (`envo_ctrl_cmd`) and the evolve engine. It owns the shared single-port cell memory and grants it to one of four activities: clear sweep, random fill, user cell write, or evolution step. It paces evolution steps from a programmable speed setting and supports pause and single-step.

## Interface
- `MAP_WIDTH`, 16, cells per row.
- `MAP_HEIGHT`, 16, cells per column.
- `DIV_BASE`, 1_000_000, clk cycles per tick at the fastest speed.
- `SPEED_MAX`, 7, highest speed index.
- Derived: `AW = clog2(MAP_WIDTH*MAP_HEIGHT)`.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; asynchronous and active-high.
- `envo_ctrl_cmd`  in  8  one-cycle command pulses:
  - bit0 CLR, bit1 INC_V, bit2 DEC_V, bit3 CUR_USER_DATA (value to write), bit4 CUR_USER_SET.
  - bit5 RANDOM, bit6 PAUSE (toggle), bit7 STEP.
- `cursor_x`, `cursor_y`  in  7 each  cursor cell coordinates.
- `mem_addr`  out  AW  cell address, `y*MAP_WIDTH + x`.
- `mem_wdata`  out  1  cell write value.
- `mem_we`  out  1  cell write strobe.
- `gen_start`  out  1  one-cycle pulse; evolve engine begins one generation.
- `gen_done`  in  1  one-cycle pulse from the engine; generation committed.
- `speed`  out  3  current speed index.
- `paused`  out  1  evolution paused.
- `busy`  out  1  scheduler not in IDLE.
- `gen_count`  out  16  generations completed, wraps at 16'hFFFF→0.
- `state`  out  3  FSM state code, for the LED/seg debug display.

## Operation
- FSM states: IDLE=0, CLEAR=1, RANDOM=2, USET=3, EVOLVE=4.
- Command pulses in any state set sticky pending flags: `p_clr`, `p_rnd`, `p_set`, `p_step`.
  - A repeated pulse while a flag is pending is absorbed.
  - CUR_USER_DATA is sampled into `set_val` together with CUR_USER_SET.
- INC_V/DEC_V act immediately in any state. `speed` saturates at SPEED_MAX and at 0.
- PAUSE toggles `paused` immediately.
- Pace counter:
  - Counts only while `paused`=0.
  - Period = `DIV_BASE << (SPEED_MAX - speed)`.
  - At terminal count it sets `p_tick` and restarts.
  - A speed change restarts the counter at 0.
- From IDLE, priority is CLR > RANDOM > USET > (`p_tick` or `p_step`) → EVOLVE. The selected flag clears on entry.
- CLEAR: sweeps addr 0..N-1 with `mem_we`=1 and `mem_wdata`=0, one cell per cycle, N = MAP_WIDTH*MAP_HEIGHT. After addr N-1 → IDLE. `gen_count` is reset to 0.
- RANDOM: same sweep; `mem_wdata` = LFSR bit0.
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1.
  - Advances every clk, not only during the sweep.
- USET: one cycle. Writes `set_val` at the cursor address, then → IDLE.
  - If `cursor_x >= MAP_WIDTH` or `cursor_y >= MAP_HEIGHT`, no write occurs (`mem_we`=0).
- EVOLVE:
  - `gen_start` pulses on the entry cycle. Scheduler memory outputs are held inactive while the engine owns the memory.
  - Waits for `gen_done`; on `gen_done`, `gen_count`+1 and → IDLE.
  - A CLR arriving during EVOLVE stays pending until the generation completes. No preemption.
- STEP while not paused behaves as an extra tick.

## Timing
- Reset values:
  - State IDLE; all pending flags 0.
  - `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `gen_start`=0.
  - `speed`=3, `paused`=0, `busy`=0, `gen_count`=0, LFSR=16'hACE1, pace counter 0.
- All outputs are registered.
- A command pulse at cycle t, with the FSM in IDLE and no higher-priority flag pending, gives first memory activity at cycle t+2: flag set at t+1, state entry at t+2.
- CLEAR/RANDOM occupy exactly N cycles with `mem_we` high; `busy` is high for N cycles.
- USET: `busy` high for 1 cycle.
- EVOLVE: `gen_start` at entry; the return to IDLE occurs the cycle after `gen_done`. `gen_done` outside EVOLVE is ignored.
- Same-cycle CLR and RANDOM: both flags are set; CLEAR runs first, then RANDOM.
- Asynchronous `rst` mid-sweep: immediate return to reset values. Memory is left partially written; this is acceptable.
- Pace terminal count during CLEAR: `p_tick` is held; EVOLVE follows after the sweep.

## Structure
- Shared `defines.v` holds the command bit indices (CLR..STEP) and the state codes.
- Natural sub-module: `lfsr16` (clk, rst, out[15:0]).
- The pace divider stays inline.

## Test plan
- Reset, then CLR pulse → `mem_we` high for 256 consecutive cycles, addresses 0..255, `mem_wdata`=0; `busy` drops afterwards; `gen_count`=0.
- `cursor_x`=5, `cursor_y`=2, CUR_USER_SET with CUR_USER_DATA=1 → a single write at `mem_addr`=37 with `mem_wdata`=1.
- `cursor_x`=20, CUR_USER_SET → no `mem_we`; FSM returns to IDLE after 1 cycle.
- `DIV_BASE`=4, `speed`=7 → `gen_start` every 4 cycles plus engine latency; with `gen_done` returned after 3 cycles, `gen_count` increments on each.
- PAUSE, then STEP ×2 → exactly two `gen_start` pulses and `gen_count`=2; no further starts over 1000 cycles.
- CLR and RANDOM in the same cycle during EVOLVE → after `gen_done`, a CLEAR sweep followed by a RANDOM sweep whose first 16 `mem_wdata` bits match the LFSR model; INC_V ×6 from reset → `speed`=7.
